// File: rtl/csi_video_pkg.sv
// Shared definitions for the CSI line framer: FSM encoding, sideband flag layout
// and default geometry.
package csi_video_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_FRAME = 2'd0,
    ST_IN_LINE    = 2'd1,
    ST_LINE_GAP   = 2'd2
  } csi_state_e;

  localparam int FLAG_W       = 2;
  localparam int FLAG_SOF_BIT = 1;
  localparam int FLAG_EOL_BIT = 0;

  localparam int DEF_LINE_WORDS  = 320;
  localparam int DEF_FRAME_LINES = 480;

  function automatic logic [FLAG_W-1:0] pack_flags(input logic sof, input logic eol);
    logic [FLAG_W-1:0] f;
    f               = {FLAG_W{1'b0}};
    f[FLAG_SOF_BIT] = sof;
    f[FLAG_EOL_BIT] = eol;
    return f;
  endfunction

endpackage

// File: rtl/csi_sync_fifo.sv
// Single-clock FIFO with full/empty flags; head entry is presented without a read
// strobe. A write while full is accepted only when a read frees a slot that cycle.
module csi_sync_fifo #(
  parameter int W     = 18,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_wr,
  input  logic [W-1:0] i_wdata,
  input  logic         i_rd,
  output logic [W-1:0] o_rdata,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          w_do_rd;
  logic          w_do_wr;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == {CW{1'b0}});
  assign o_rdata = r_mem[r_rptr];
  assign w_do_rd = i_rd & ~o_empty;
  assign w_do_wr = i_wr & (~o_full | w_do_rd);

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {W{1'b0}};
      end
      r_wptr  <= {AW{1'b0}};
      r_rptr  <= {AW{1'b0}};
      r_count <= {CW{1'b0}};
    end else begin
      if (w_do_wr) begin
        r_mem[r_wptr] <= i_wdata;
        r_wptr        <= r_wptr + AW'(1);
      end
      if (w_do_rd) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_do_wr, w_do_rd})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/csi_line_framer.sv
// Frames a raw CSI payload word stream into lines and frames, tags sof/eol,
// tracks line/frame counters and sticky error flags, and buffers into a FIFO.
module csi_line_framer
  import csi_video_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int LINE_WORDS  = DEF_LINE_WORDS,
  parameter int FRAME_LINES = DEF_FRAME_LINES,
  parameter int VGAP_CYCLES = 1024,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              err_clr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sof,
  output logic              out_eol,
  output logic [15:0]       line_count,
  output logic [15:0]       frame_count,
  output logic              err_short,
  output logic              err_long,
  output logic              err_ovf
);

  localparam int WCW = $clog2(LINE_WORDS + 1);
  localparam int GCW = $clog2(VGAP_CYCLES + 1);
  localparam int FW  = DATA_W + FLAG_W;

  localparam logic [WCW-1:0] LW_V   = WCW'(LINE_WORDS);
  localparam logic [WCW-1:0] LW_M1  = WCW'(LINE_WORDS - 1);
  localparam logic [WCW-1:0] WC_ONE = WCW'(1);
  localparam logic [GCW-1:0] VG_M1  = GCW'(VGAP_CYCLES - 1);
  localparam logic [15:0]    FL_M1  = 16'(FRAME_LINES - 1);
  localparam logic           FIRST_EOL = (LINE_WORDS == 1);

  csi_state_e     r_state;
  logic [WCW-1:0] r_word_cnt;
  logic [GCW-1:0] r_gap_cnt;
  logic [15:0]    r_line_count;
  logic [15:0]    r_frame_count;
  logic           r_err_short;
  logic           r_err_long;
  logic           r_err_ovf;

  logic           w_wr;
  logic           w_sof;
  logic           w_eol;
  logic           w_long_evt;
  logic           w_short_evt;
  logic           w_frame_done;
  logic           w_rd;
  logic           w_ovf_evt;
  logic           w_full;
  logic           w_empty;
  logic [FW-1:0]  w_wdata;
  logic [FW-1:0]  w_rdata;

  // Per-cycle decode of the incoming word: tag, keep/drop, and line-end events.
  always_comb begin
    w_wr         = 1'b0;
    w_sof        = 1'b0;
    w_eol        = 1'b0;
    w_long_evt   = 1'b0;
    w_short_evt  = 1'b0;
    w_frame_done = 1'b0;
    case (r_state)
      ST_WAIT_FRAME: begin
        if (in_valid) begin
          w_wr  = 1'b1;
          w_sof = 1'b1;
          w_eol = FIRST_EOL;
        end else begin
          w_wr = 1'b0;
        end
      end
      ST_IN_LINE: begin
        if (in_valid) begin
          if (r_word_cnt < LW_V) begin
            w_wr  = 1'b1;
            w_eol = (r_word_cnt == LW_M1);
          end else begin
            w_long_evt = 1'b1;
          end
        end else begin
          w_short_evt = (r_word_cnt < LW_V);
        end
      end
      ST_LINE_GAP: begin
        // A word arriving on the frame-closing cycle opens the next frame.
        w_frame_done = (r_line_count == FL_M1) || (r_gap_cnt >= VG_M1);
        if (in_valid) begin
          w_wr  = 1'b1;
          w_sof = w_frame_done;
          w_eol = FIRST_EOL;
        end else begin
          w_wr = 1'b0;
        end
      end
      default: begin
        w_wr = 1'b0;
      end
    endcase
  end

  assign w_wdata   = {in_data, pack_flags(w_sof, w_eol)};
  assign w_rd      = out_valid & out_ready;
  assign w_ovf_evt = w_wr & w_full & ~w_rd;

  // Line/frame state machine and its counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_WAIT_FRAME;
      r_word_cnt    <= {WCW{1'b0}};
      r_gap_cnt     <= {GCW{1'b0}};
      r_line_count  <= 16'd0;
      r_frame_count <= 16'd0;
    end else begin
      case (r_state)
        ST_WAIT_FRAME: begin
          if (in_valid) begin
            r_state      <= ST_IN_LINE;
            r_word_cnt   <= WC_ONE;
            r_line_count <= 16'd0;
          end
        end
        ST_IN_LINE: begin
          if (in_valid) begin
            if (r_word_cnt < LW_V) begin
              r_word_cnt <= r_word_cnt + WC_ONE;
            end
          end else begin
            r_state   <= ST_LINE_GAP;
            r_gap_cnt <= {GCW{1'b0}};
          end
        end
        ST_LINE_GAP: begin
          if (w_frame_done) begin
            r_frame_count <= r_frame_count + 16'd1;
            if (in_valid) begin
              r_state      <= ST_IN_LINE;
              r_word_cnt   <= WC_ONE;
              r_line_count <= 16'd0;
            end else begin
              r_state <= ST_WAIT_FRAME;
            end
          end else if (in_valid) begin
            r_state      <= ST_IN_LINE;
            r_word_cnt   <= WC_ONE;
            r_line_count <= r_line_count + 16'd1;
          end else begin
            r_gap_cnt <= r_gap_cnt + GCW'(1);
          end
        end
        default: begin
          r_state <= ST_WAIT_FRAME;
        end
      endcase
    end
  end

  // Sticky error flags; a same-cycle event overrides the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_short <= 1'b0;
      r_err_long  <= 1'b0;
      r_err_ovf   <= 1'b0;
    end else begin
      r_err_short <= w_short_evt | (r_err_short & ~err_clr);
      r_err_long  <= w_long_evt  | (r_err_long  & ~err_clr);
      r_err_ovf   <= w_ovf_evt   | (r_err_ovf   & ~err_clr);
    end
  end

  csi_sync_fifo #(
    .W     (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_wr    (w_wr),
    .i_wdata (w_wdata),
    .i_rd    (w_rd),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign out_valid   = ~w_empty;
  assign out_data    = w_rdata[FW-1:FLAG_W];
  assign out_sof     = w_rdata[FLAG_SOF_BIT];
  assign out_eol     = w_rdata[FLAG_EOL_BIT];
  assign line_count  = r_line_count;
  assign frame_count = r_frame_count;
  assign err_short   = r_err_short;
  assign err_long    = r_err_long;
  assign err_ovf     = r_err_ovf;

endmodule

// File: tb/tb_csi_line_framer.sv
// Scoreboard bench for csi_line_framer: line-level stimulus, a frame/FIFO
// reference model feeding an expected-word queue, and an output monitor.
module tb_csi_line_framer;

  localparam int DW    = 16;
  localparam int LW    = 4;
  localparam int FL    = 3;
  localparam int VG    = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          err_clr = 1'b0;
  logic          out_ready = 1'b0;
  logic          out_valid, out_sof, out_eol;
  logic [DW-1:0] out_data;
  logic [15:0]   line_count, frame_count;
  logic          err_short, err_long, err_ovf;

  always #5 clk = ~clk;

  csi_line_framer #(
    .DATA_W(DW), .LINE_WORDS(LW), .FRAME_LINES(FL), .VGAP_CYCLES(VG), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .err_clr(err_clr),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sof(out_sof),
    .out_eol(out_eol), .line_count(line_count), .frame_count(frame_count),
    .err_short(err_short), .err_long(err_long), .err_ovf(err_ovf)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: expected output words, FIFO occupancy, frame position.
  logic [DW+1:0] exp_q[$];
  int            occ = 0;
  bit            exp_vld_now = 1'b0;
  int            rdy_mode = 0;
  int            m_line = 0;
  int            m_frames = 0;
  int            m_idle = 0;
  bit            m_open = 1'b0;
  bit            m_short = 1'b0, m_long = 1'b0, m_ovf = 1'b0;
  logic [DW-1:0] m_data = 16'h0001;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every cycle check out_valid, and on a transfer pop and compare.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("out_valid", out_valid, exp_vld_now);
      if (out_valid && out_ready) begin
        chk("word_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          chk("word", {out_sof, out_eol, out_data}, exp_q.pop_front());
        end
      end
    end
  end

  // One clock of stimulus; the model decides what the FIFO will hold after it.
  task automatic step(input bit v, input bit emit, input bit sof, input bit eol, input bit clr);
    bit rd;
    @(posedge clk);
    #1;
    in_valid = v;
    in_data  = v ? m_data : 16'h0000;
    err_clr  = clr;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
    exp_vld_now = (occ > 0);
    rd = (occ > 0) && out_ready;
    if (v && emit) begin
      if (occ < DEPTH || rd) begin
        exp_q.push_back({sof, eol, m_data});
        occ++;
      end else begin
        m_ovf = 1'b1;
      end
    end
    if (rd) occ--;
    if (v) begin
      m_data++;
      m_idle = 0;
    end else begin
      m_idle++;
      if (m_open && m_idle == VG + 1) begin
        m_frames++;
        m_line = 0;
        m_open = 1'b0;
      end
    end
    if (clr) begin
      m_short = 1'b0;
      m_long  = 1'b0;
      m_ovf   = 1'b0;
    end
  endtask

  task automatic drive_line(input int len, input int gap);
    int lc_exp;
    for (int i = 0; i < len; i++) begin
      step(1'b1, i < LW, (i == 0) && (m_line == 0), i == LW - 1, 1'b0);
    end
    lc_exp = m_line;
    if (len < LW) m_short = 1'b1;
    if (len > LW) m_long = 1'b1;
    if (m_line == FL - 1) begin
      m_frames++;
      m_line = 0;
      m_open = 1'b0;
    end else begin
      m_line++;
      m_open = 1'b1;
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("line_count", line_count, lc_exp);
    for (int g = 1; g < gap; g++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    if (gap >= 3) chk("frame_count", frame_count, m_frames);
    chk("err_short", err_short, m_short);
    chk("err_long", err_long, m_long);
    chk("err_ovf", err_ovf, m_ovf);
  endtask

  task automatic clear_errs();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("err_clr", {err_short, err_long, err_ovf}, 3'b000);
  endtask

  task automatic drain();
    int n = 0;
    rdy_mode = 0;
    while ((occ > 0 || m_idle < 12) && n < 300) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      n++;
    end
    if (n >= 300) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: occupancy=%0d idle=%0d", occ, m_idle);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    err_clr  = 1'b0;
    exp_q.delete();
    occ = 0; exp_vld_now = 1'b0;
    m_line = 0; m_frames = 0; m_idle = 0; m_open = 1'b0;
    m_short = 1'b0; m_long = 1'b0; m_ovf = 1'b0;
    #2;
    chk("rst_flags", {out_valid, out_sof, out_eol, err_short, err_long, err_ovf}, 6'd0);
    chk("rst_data", out_data, 16'h0000);
    chk("rst_counts", {line_count, frame_count}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int len, gap, r;
    do_reset();

    // Full frame of three 4-word lines.
    drive_line(4, 2);
    drive_line(4, 2);
    drive_line(4, 3);
    chk("frame1_count", frame_count, 16'd1);

    // Short line closed by a long idle gap.
    drive_line(3, 12);
    chk("short_flag", err_short, 1'b1);
    clear_errs();

    // Long line: extra words dropped.
    drive_line(6, 3);
    chk("long_flag", err_long, 1'b1);
    clear_errs();

    // Backpressure: fifth write while full overflows.
    drain();
    rdy_mode = 2;
    drive_line(4, 3);
    drive_line(1, 3);
    drain();
    chk("ovf_flag", err_ovf, 1'b1);
    clear_errs();

    // Full FIFO with a simultaneous read and write.
    drain();
    rdy_mode = 2;
    drive_line(4, 3);
    rdy_mode = 0;
    drive_line(4, 3);
    chk("no_ovf_full_rw", err_ovf, 1'b0);

    // Reset in the middle of a line.
    drain();
    drive_line(4, 3);
    step(1'b1, 1'b1, m_line == 0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    do_reset();
    drive_line(4, 12);
    clear_errs();

    // Randomized lines, gaps and backpressure.
    for (int k = 0; k < 40; k++) begin
      rdy_mode = $urandom_range(0, 1);
      r   = $urandom_range(0, 5);
      len = (r < 4) ? LW : $urandom_range(1, 6);
      r   = $urandom_range(0, 4);
      gap = (r < 3) ? 2 + r : 12 + $urandom_range(0, 2);
      drive_line(len, gap);
      if ($urandom_range(0, 3) == 0) clear_errs();
    end

    drain();
    chk("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/csi_line_framer.md
CSI_LINE_FRAMER -- requirements
Module: csi_line_framer

Interface
REQ-001 Parameter DATA_W, default 16, payload word width (NUM_LANES*NUM_RAW).
REQ-002 Parameter LINE_WORDS, default 320, words per active line.
REQ-003 Parameter FRAME_LINES, default 480, lines per frame.
REQ-004 Parameter VGAP_CYCLES, default 1024, idle cycles declaring end of frame.
REQ-005 Parameter FIFO_DEPTH, default 4, output FIFO entries (power of two, at least 2).
REQ-006 clk  input  1  csi_byte_clk domain; the only clock.
REQ-007 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-008 in_valid  input  1  raw payload word strobe (csi_raw_valid); no backpressure.
REQ-009 in_data  input  DATA_W  raw payload word (csi_raw_data).
REQ-010 err_clr  input  1  synchronous clear of sticky error flags.
REQ-011 out_valid  output  1  output word available.
REQ-012 out_ready  input  1  consumer accepts the word.
REQ-013 out_data  output  DATA_W  framed payload word.
REQ-014 out_sof  output  1  word is first of frame.
REQ-015 out_eol  output  1  word is last of line.
REQ-016 line_count  output  16  current line index within frame.
REQ-017 frame_count  output  16  completed frames, wraps at 65535 to 0.
REQ-018 err_short, err_long, err_ovf  output  1 each  sticky short-line, long-line and FIFO-overflow flags.

Function
REQ-019 FSM states: WAIT_FRAME, IN_LINE, LINE_GAP.
REQ-020 WAIT_FRAME: on in_valid go to IN_LINE, set word_cnt to 1 and line_count to 0, and tag the word sof=1.
REQ-021 IN_LINE: each in_valid increments word_cnt; in_valid low goes to LINE_GAP and clears gap_cnt.
REQ-022 Word with word_cnt index LINE_WORDS-1 (0-based) tagged eol=1.
REQ-023 Words beyond index LINE_WORDS-1 in one line are dropped and set err_long.
REQ-024 Line ending with fewer than LINE_WORDS words sets err_short; no eol emitted for that line.
REQ-025 LINE_GAP: in_valid goes to IN_LINE, increments line_count, and restarts word_cnt at 1.
REQ-026 LINE_GAP: gap_cnt increments each idle cycle; reaching VGAP_CYCLES-1 goes to WAIT_FRAME and increments frame_count.
REQ-027 LINE_GAP: when line_count equals FRAME_LINES-1 and the line has ended, go directly to WAIT_FRAME and increment frame_count.
REQ-028 A frame_count increment fires once per frame even if both REQ-026 and REQ-027 conditions hold.
REQ-029 Tagged words enter a FIFO_DEPTH FIFO; out_data, out_sof and out_eol come from the FIFO head.
REQ-030 Latency: a word accepted at cycle N with the FIFO empty shows out_valid=1 at cycle N+1.
REQ-031 A word transfers when out_valid and out_ready are both 1; out_valid never depends combinationally on out_ready.
REQ-032 Write when full with no simultaneous read: the word is dropped, err_ovf is set, and counters still advance.
REQ-033 Write when full with a simultaneous read: the write is accepted with no overflow.
REQ-034 err_clr clears all sticky flags next cycle; an error event in the same cycle wins and the flag stays 1.

Reset
REQ-035 rst_n low: FSM=WAIT_FRAME and FIFO empty.
REQ-036 rst_n low: out_valid, out_sof, out_eol, line_count, frame_count and all error flags are 0; out_data is 0.
REQ-037 Reset mid-line discards the partial line; the first in_valid after release is sof.

Structure
REQ-038 Shared package csi_video_pkg holds the FSM state encoding, the flag bit positions {sof,eol}, and the default LINE_WORDS/FRAME_LINES constants.
REQ-039 One sub-module: csi_sync_fifo, a single-clock FIFO of width DATA_W+2 with full/empty flags and async active-low reset.

Verification (LINE_WORDS=4, FRAME_LINES=3, VGAP_CYCLES=8, FIFO_DEPTH=4, out_ready=1 unless stated)
REQ-040 3 lines of 4 words 0x0001..0x000C, gaps of 2 cycles -> sof on 0x0001; eol on 0x0004, 0x0008 and 0x000C; frame_count=1; no errors.
REQ-041 Line of 3 words then 10 idle cycles -> err_short=1, no eol, frame_count=1; next word has sof=1.
REQ-042 Line of 6 words -> 4 words output, eol on 4th, err_long=1; pulse err_clr -> flag 0 next cycle.
REQ-043 out_ready=0 and 5-word burst -> 4 words held, err_ovf=1; release ready -> words 1..4 output in order.
REQ-044 rst_n low for 1 cycle after word 2 of a line -> all outputs 0; next in_valid -> sof=1, line_count=0.
REQ-045 FIFO full with out_ready=1 and in_valid in the same cycle -> no err_ovf, occupancy unchanged.
